// File: rtl/axi4_mmio_master_pkg.sv
// Shared types and constants for the single-outstanding AXI4 MMIO initiator.
package axi4_mmio_pkg;

  localparam int MMIO_ADDR_W = 31;
  localparam int MMIO_DATA_W = 64;
  localparam int MMIO_ID_W   = 4;
  localparam int MMIO_STRB_W = MMIO_DATA_W / 8;

  // Transaction sequencer states
  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_WR    = 3'd1,
    ST_WR_B  = 3'd2,
    ST_RD_AR = 3'd3,
    ST_RD_R  = 3'd4,
    ST_RESP  = 3'd5
  } state_t;

  // Response codes returned on the command port
  localparam logic [1:0] RC_OK       = 2'd0;
  localparam logic [1:0] RC_MISALIGN = 2'd1;
  localparam logic [1:0] RC_BUSERR   = 2'd2;
  localparam logic [1:0] RC_PROTO    = 2'd3;

  localparam logic [1:0] AXI_BURST_INCR = 2'b01;

  localparam logic [1:0] AXI_RESP_OKAY   = 2'b00;
  localparam logic [1:0] AXI_RESP_EXOKAY = 2'b01;
  localparam logic [1:0] AXI_RESP_SLVERR = 2'b10;
  localparam logic [1:0] AXI_RESP_DECERR = 2'b11;

  // An access is misaligned when its size exceeds the 64-bit bus or when any
  // address bit below the access size is set.
  function automatic logic is_misaligned(input logic [2:0] addr_lo, input logic [2:0] size);
    logic [3:0] span;
    logic [2:0] mask;
    span = 4'd1 << size[1:0];
    mask = span[2:0] - 3'd1;
    if (size > 3'd3) begin
      return 1'b1;
    end
    return (addr_lo & mask) != 3'd0;
  endfunction

endpackage

// File: rtl/axi4_mmio_master_if.sv
// AXI4 single-beat bus between the MMIO initiator and the peripheral crossbar.
// Handshake rule for every channel: a beat transfers on a rising clock edge
// where valid and ready are both high; the source holds valid and payload
// stable until that edge and never waits on ready before raising valid.
interface axi4_mmio_master_if
  import axi4_mmio_pkg::*;
#(
  parameter int ADDR_W = MMIO_ADDR_W,
  parameter int DATA_W = MMIO_DATA_W,
  parameter int ID_W   = MMIO_ID_W
) ();
  localparam int STRB_W = DATA_W / 8;

  logic              aw_valid;
  logic              aw_ready;
  logic [ID_W-1:0]   aw_id;
  logic [ADDR_W-1:0] aw_addr;
  logic [7:0]        aw_len;
  logic [2:0]        aw_size;
  logic [1:0]        aw_burst;

  logic              w_valid;
  logic              w_ready;
  logic [DATA_W-1:0] w_data;
  logic [STRB_W-1:0] w_strb;
  logic              w_last;

  logic              b_valid;
  logic              b_ready;
  logic [ID_W-1:0]   b_id;
  logic [1:0]        b_resp;

  logic              ar_valid;
  logic              ar_ready;
  logic [ID_W-1:0]   ar_id;
  logic [ADDR_W-1:0] ar_addr;
  logic [7:0]        ar_len;
  logic [2:0]        ar_size;
  logic [1:0]        ar_burst;

  logic              r_valid;
  logic              r_ready;
  logic [ID_W-1:0]   r_id;
  logic [DATA_W-1:0] r_data;
  logic [1:0]        r_resp;
  logic              r_last;

  modport master (
    output aw_valid, aw_id, aw_addr, aw_len, aw_size, aw_burst,
    input  aw_ready,
    output w_valid, w_data, w_strb, w_last,
    input  w_ready,
    input  b_valid, b_id, b_resp,
    output b_ready,
    output ar_valid, ar_id, ar_addr, ar_len, ar_size, ar_burst,
    input  ar_ready,
    input  r_valid, r_id, r_data, r_resp, r_last,
    output r_ready
  );

  modport slave (
    input  aw_valid, aw_id, aw_addr, aw_len, aw_size, aw_burst,
    output aw_ready,
    input  w_valid, w_data, w_strb, w_last,
    output w_ready,
    output b_valid, b_id, b_resp,
    input  b_ready,
    input  ar_valid, ar_id, ar_addr, ar_len, ar_size, ar_burst,
    output ar_ready,
    output r_valid, r_id, r_data, r_resp, r_last,
    input  r_ready
  );

endinterface

// File: rtl/axi4_mmio_master.sv
// Single-outstanding AXI4 initiator: one command in, one single-beat AXI
// read or write out, one response back. All bus outputs come from flops.
module axi4_mmio_master
  import axi4_mmio_pkg::*;
#(
  parameter int              ADDR_W = MMIO_ADDR_W,
  parameter int              DATA_W = MMIO_DATA_W,
  parameter int              ID_W   = MMIO_ID_W,
  parameter logic [ID_W-1:0] AXI_ID = '0,
  localparam int             STRB_W = DATA_W / 8
) (
  input  logic               clock,
  input  logic               reset,
  input  logic               req_valid,
  output logic               req_ready,
  input  logic               req_write,
  input  logic [ADDR_W-1:0]  req_addr,
  input  logic [2:0]         req_size,
  input  logic [DATA_W-1:0]  req_wdata,
  input  logic [STRB_W-1:0]  req_wstrb,
  output logic               resp_valid,
  input  logic               resp_ready,
  output logic [DATA_W-1:0]  resp_rdata,
  output logic               resp_err,
  output logic [1:0]         resp_code,
  axi4_mmio_master_if.master m_axi4,
  output state_t             dbg_state
);

  state_t              state_q, state_d;
  logic                aw_valid_q, aw_valid_d;
  logic                w_valid_q, w_valid_d;
  logic                ar_valid_q, ar_valid_d;
  logic                b_ready_q, b_ready_d;
  logic                r_ready_q, r_ready_d;
  logic [ADDR_W-1:0]   addr_q, addr_d;
  logic [2:0]          size_q, size_d;
  logic [DATA_W-1:0]   wdata_q, wdata_d;
  logic [STRB_W-1:0]   wstrb_q, wstrb_d;
  logic [DATA_W-1:0]   rdata_q, rdata_d;
  logic [1:0]          code_q, code_d;

  logic                aw_done;
  logic                w_done;
  logic [1:0]          b_code;
  logic [1:0]          r_code;

  // AW and W complete independently; a channel is done once its valid has
  // dropped or its handshake lands this cycle.
  assign aw_done = !aw_valid_q || m_axi4.aw_ready;
  assign w_done  = !w_valid_q  || m_axi4.w_ready;

  // Classify the write response: wrong ID beats a bus error.
  always_comb begin
    b_code = RC_OK;
    if (m_axi4.b_id != AXI_ID) begin
      b_code = RC_PROTO;
    end else if (m_axi4.b_resp == AXI_RESP_SLVERR || m_axi4.b_resp == AXI_RESP_DECERR) begin
      b_code = RC_BUSERR;
    end
  end

  // Classify the read beat: wrong ID or missing last beats a bus error.
  always_comb begin
    r_code = RC_OK;
    if (m_axi4.r_id != AXI_ID || !m_axi4.r_last) begin
      r_code = RC_PROTO;
    end else if (m_axi4.r_resp == AXI_RESP_SLVERR || m_axi4.r_resp == AXI_RESP_DECERR) begin
      r_code = RC_BUSERR;
    end
  end

  // State and datapath registers with synchronous reset.
  always_ff @(posedge clock) begin
    if (reset) begin
      state_q    <= ST_IDLE;
      aw_valid_q <= 1'b0;
      w_valid_q  <= 1'b0;
      ar_valid_q <= 1'b0;
      b_ready_q  <= 1'b0;
      r_ready_q  <= 1'b0;
      addr_q     <= '0;
      size_q     <= '0;
      wdata_q    <= '0;
      wstrb_q    <= '0;
      rdata_q    <= '0;
      code_q     <= RC_OK;
    end else begin
      state_q    <= state_d;
      aw_valid_q <= aw_valid_d;
      w_valid_q  <= w_valid_d;
      ar_valid_q <= ar_valid_d;
      b_ready_q  <= b_ready_d;
      r_ready_q  <= r_ready_d;
      addr_q     <= addr_d;
      size_q     <= size_d;
      wdata_q    <= wdata_d;
      wstrb_q    <= wstrb_d;
      rdata_q    <= rdata_d;
      code_q     <= code_d;
    end
  end

  // Next-state and next-register values for the transaction sequencer.
  always_comb begin
    state_d    = state_q;
    aw_valid_d = aw_valid_q;
    w_valid_d  = w_valid_q;
    ar_valid_d = ar_valid_q;
    b_ready_d  = b_ready_q;
    r_ready_d  = r_ready_q;
    addr_d     = addr_q;
    size_d     = size_q;
    wdata_d    = wdata_q;
    wstrb_d    = wstrb_q;
    rdata_d    = rdata_q;
    code_d     = code_q;
    unique case (state_q)
      ST_IDLE: begin
        if (req_valid) begin
          addr_d  = req_addr;
          size_d  = req_size;
          wdata_d = req_wdata;
          wstrb_d = req_wstrb;
          rdata_d = '0;
          code_d  = RC_OK;
          if (is_misaligned(req_addr[2:0], req_size)) begin
            code_d  = RC_MISALIGN;
            state_d = ST_RESP;
          end else if (req_write) begin
            aw_valid_d = 1'b1;
            w_valid_d  = 1'b1;
            state_d    = ST_WR;
          end else begin
            ar_valid_d = 1'b1;
            state_d    = ST_RD_AR;
          end
        end
      end
      ST_WR: begin
        if (aw_valid_q && m_axi4.aw_ready) begin
          aw_valid_d = 1'b0;
        end
        if (w_valid_q && m_axi4.w_ready) begin
          w_valid_d = 1'b0;
        end
        if (aw_done && w_done) begin
          b_ready_d = 1'b1;
          state_d   = ST_WR_B;
        end
      end
      ST_WR_B: begin
        if (m_axi4.b_valid) begin
          b_ready_d = 1'b0;
          code_d    = b_code;
          state_d   = ST_RESP;
        end
      end
      ST_RD_AR: begin
        if (m_axi4.ar_ready) begin
          ar_valid_d = 1'b0;
          r_ready_d  = 1'b1;
          state_d    = ST_RD_R;
        end
      end
      ST_RD_R: begin
        if (m_axi4.r_valid) begin
          r_ready_d = 1'b0;
          code_d    = r_code;
          rdata_d   = (r_code == RC_OK) ? m_axi4.r_data : '0;
          state_d   = ST_RESP;
        end
      end
      ST_RESP: begin
        if (resp_ready) begin
          code_d  = RC_OK;
          rdata_d = '0;
          state_d = ST_IDLE;
        end
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // Command-port outputs decoded from the current state.
  always_comb begin
    req_ready  = (state_q == ST_IDLE);
    resp_valid = (state_q == ST_RESP);
    resp_code  = code_q;
    resp_err   = (code_q != RC_OK);
    resp_rdata = rdata_q;
    dbg_state  = state_q;
  end

  // Bus channels: fixed single-beat INCR bursts carrying the latched command.
  assign m_axi4.aw_valid = aw_valid_q;
  assign m_axi4.aw_id    = AXI_ID;
  assign m_axi4.aw_addr  = addr_q;
  assign m_axi4.aw_len   = 8'd0;
  assign m_axi4.aw_size  = size_q;
  assign m_axi4.aw_burst = AXI_BURST_INCR;
  assign m_axi4.w_valid  = w_valid_q;
  assign m_axi4.w_data   = wdata_q;
  assign m_axi4.w_strb   = wstrb_q;
  assign m_axi4.w_last   = 1'b1;
  assign m_axi4.b_ready  = b_ready_q;
  assign m_axi4.ar_valid = ar_valid_q;
  assign m_axi4.ar_id    = AXI_ID;
  assign m_axi4.ar_addr  = addr_q;
  assign m_axi4.ar_len   = 8'd0;
  assign m_axi4.ar_size  = size_q;
  assign m_axi4.ar_burst = AXI_BURST_INCR;
  assign m_axi4.r_ready  = r_ready_q;

endmodule

// File: tb/tb_axi4_mmio_master.sv
// Directed and randomized bench for axi4_mmio_master with a cycle-level AXI
// slave responder and a rule-based reference model for responses.
module tb_axi4_mmio_master;
  import axi4_mmio_pkg::*;

  localparam int AW = 31;
  localparam int DW = 64;
  localparam int IW = 4;
  localparam int SW = DW / 8;

  // ---------------- clock / reset ----------------
  logic clock = 1'b0;
  logic reset;
  always #5 clock = ~clock;

  logic          req_valid;
  logic          req_ready;
  logic          req_write;
  logic [AW-1:0] req_addr;
  logic [2:0]    req_size;
  logic [DW-1:0] req_wdata;
  logic [SW-1:0] req_wstrb;
  logic          resp_valid;
  logic          resp_ready;
  logic [DW-1:0] resp_rdata;
  logic          resp_err;
  logic [1:0]    resp_code;
  state_t        dbg_state;

  axi4_mmio_master_if #(.ADDR_W(AW), .DATA_W(DW), .ID_W(IW)) m_axi4 ();

  axi4_mmio_master dut (
    .clock      (clock),
    .reset      (reset),
    .req_valid  (req_valid),
    .req_ready  (req_ready),
    .req_write  (req_write),
    .req_addr   (req_addr),
    .req_size   (req_size),
    .req_wdata  (req_wdata),
    .req_wstrb  (req_wstrb),
    .resp_valid (resp_valid),
    .resp_ready (resp_ready),
    .resp_rdata (resp_rdata),
    .resp_err   (resp_err),
    .resp_code  (resp_code),
    .m_axi4     (m_axi4),
    .dbg_state  (dbg_state)
  );

  // ---------------- counters / scoreboard ----------------
  int n_vec = 0;
  int n_err = 0;
  logic [65:0] exp_q[$];

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // ---------------- slave configuration ----------------
  int          aw_delay, w_delay, ar_delay, b_delay, r_delay;
  logic [1:0]  cfg_b_resp, cfg_r_resp;
  logic [3:0]  cfg_b_id, cfg_r_id;
  logic        cfg_r_last;
  logic [63:0] cfg_r_data;

  task automatic slave_defaults();
    aw_delay = 0; w_delay = 0; ar_delay = 0; b_delay = 0; r_delay = 0;
    cfg_b_resp = 2'b00; cfg_r_resp = 2'b00;
    cfg_b_id = 4'd0; cfg_r_id = 4'd0;
    cfg_r_last = 1'b1; cfg_r_data = 64'd0;
  endtask

  // ---------------- slave observations ----------------
  int aw_seen, w_seen, ar_seen, b_done, r_done, proto_viol;
  logic [AW-1:0] cap_aw_addr, cap_ar_addr;
  logic [2:0]    cap_aw_size, cap_ar_size;
  logic [7:0]    cap_aw_len, cap_ar_len;
  logic [1:0]    cap_aw_burst, cap_ar_burst;
  logic [IW-1:0] cap_aw_id, cap_ar_id;
  logic [DW-1:0] cap_w_data;
  logic [SW-1:0] cap_w_strb;
  logic          cap_w_last;

  // Slave responder: everything changes on the falling edge; handshakes are
  // booked for the rising edge that follows.
  initial begin
    int aw_wait, w_wait, ar_wait, b_wait, r_wait;
    logic hs_b, hs_r;
    aw_wait = 0; w_wait = 0; ar_wait = 0; b_wait = 0; r_wait = 0;
    hs_b = 1'b0; hs_r = 1'b0;
    aw_seen = 0; w_seen = 0; ar_seen = 0; b_done = 0; r_done = 0; proto_viol = 0;
    m_axi4.aw_ready = 1'b0; m_axi4.w_ready = 1'b0; m_axi4.ar_ready = 1'b0;
    m_axi4.b_valid = 1'b0; m_axi4.b_id = '0; m_axi4.b_resp = '0;
    m_axi4.r_valid = 1'b0; m_axi4.r_id = '0; m_axi4.r_data = '0;
    m_axi4.r_resp = '0; m_axi4.r_last = 1'b0;
    forever begin
      @(negedge clock);
      if (reset) begin
        aw_wait = 0; w_wait = 0; ar_wait = 0; b_wait = 0; r_wait = 0;
        hs_b = 1'b0; hs_r = 1'b0;
        aw_seen = 0; w_seen = 0; ar_seen = 0; b_done = 0; r_done = 0;
        m_axi4.aw_ready = 1'b0; m_axi4.w_ready = 1'b0; m_axi4.ar_ready = 1'b0;
        m_axi4.b_valid = 1'b0; m_axi4.r_valid = 1'b0;
        continue;
      end
      if (hs_b) begin m_axi4.b_valid = 1'b0; b_done++; b_wait = 0; end
      if (hs_r) begin m_axi4.r_valid = 1'b0; r_done++; r_wait = 0; end
      m_axi4.aw_ready = m_axi4.aw_valid && (aw_wait >= aw_delay);
      aw_wait = m_axi4.aw_valid ? aw_wait + 1 : 0;
      m_axi4.w_ready = m_axi4.w_valid && (w_wait >= w_delay);
      w_wait = m_axi4.w_valid ? w_wait + 1 : 0;
      m_axi4.ar_ready = m_axi4.ar_valid && (ar_wait >= ar_delay);
      ar_wait = m_axi4.ar_valid ? ar_wait + 1 : 0;
      if (!m_axi4.b_valid && aw_seen > b_done && w_seen > b_done) begin
        if (b_wait >= b_delay) begin
          m_axi4.b_valid = 1'b1; m_axi4.b_id = cfg_b_id; m_axi4.b_resp = cfg_b_resp;
        end else b_wait++;
      end
      if (!m_axi4.r_valid && ar_seen > r_done) begin
        if (r_wait >= r_delay) begin
          m_axi4.r_valid = 1'b1; m_axi4.r_id = cfg_r_id; m_axi4.r_data = cfg_r_data;
          m_axi4.r_resp = cfg_r_resp; m_axi4.r_last = cfg_r_last;
        end else r_wait++;
      end
      // Write response may only be awaited once both AW and W have transferred.
      if (m_axi4.b_ready && !(aw_seen > b_done && w_seen > b_done)) proto_viol++;
      if (m_axi4.aw_valid && m_axi4.aw_ready) begin
        aw_seen++;
        cap_aw_addr = m_axi4.aw_addr; cap_aw_size = m_axi4.aw_size; cap_aw_len = m_axi4.aw_len;
        cap_aw_burst = m_axi4.aw_burst; cap_aw_id = m_axi4.aw_id;
      end
      if (m_axi4.w_valid && m_axi4.w_ready) begin
        w_seen++;
        cap_w_data = m_axi4.w_data; cap_w_strb = m_axi4.w_strb; cap_w_last = m_axi4.w_last;
      end
      if (m_axi4.ar_valid && m_axi4.ar_ready) begin
        ar_seen++;
        cap_ar_addr = m_axi4.ar_addr; cap_ar_size = m_axi4.ar_size; cap_ar_len = m_axi4.ar_len;
        cap_ar_burst = m_axi4.ar_burst; cap_ar_id = m_axi4.ar_id;
      end
      hs_b = m_axi4.b_valid && m_axi4.b_ready;
      hs_r = m_axi4.r_valid && m_axi4.r_ready;
    end
  end

  // ---------------- driver tasks ----------------
  task automatic check_idle(input string tag);
    chk({tag, "_aw_valid"}, m_axi4.aw_valid, 1'b0);
    chk({tag, "_w_valid"}, m_axi4.w_valid, 1'b0);
    chk({tag, "_ar_valid"}, m_axi4.ar_valid, 1'b0);
    chk({tag, "_b_ready"}, m_axi4.b_ready, 1'b0);
    chk({tag, "_r_ready"}, m_axi4.r_ready, 1'b0);
    chk({tag, "_resp_valid"}, resp_valid, 1'b0);
    chk({tag, "_resp_err"}, resp_err, 1'b0);
    chk({tag, "_resp_code"}, resp_code, 2'd0);
    chk({tag, "_resp_rdata"}, resp_rdata, 64'd0);
    chk({tag, "_req_ready"}, req_ready, 1'b1);
    chk({tag, "_state"}, dbg_state, ST_IDLE);
  endtask

  // One command end to end; expectations come from the slave configuration
  // and the access rules, never from the DUT.
  task automatic do_txn(input string tag, input logic wr, input logic [AW-1:0] addr,
                        input logic [2:0] size, input logic [DW-1:0] wdata,
                        input logic [SW-1:0] wstrb, input int hold);
    logic        misal;
    logic [1:0]  e_code;
    logic [63:0] e_rdata;
    logic [65:0] e;
    int          e_lat, aw0, w0, ar0, cyc;
    misal = (size > 3'd3) || ((int'(addr[2:0]) % (1 << int'(size))) != 0);
    e_rdata = 64'd0;
    if (misal) begin
      e_code = 2'd1; e_lat = 1;
    end else if (wr) begin
      if (cfg_b_id != 4'd0) e_code = 2'd3;
      else if (cfg_b_resp >= 2'd2) e_code = 2'd2;
      else e_code = 2'd0;
      e_lat = ((aw_delay > w_delay) ? aw_delay : w_delay) + b_delay + 3;
    end else begin
      if (cfg_r_id != 4'd0 || !cfg_r_last) e_code = 2'd3;
      else if (cfg_r_resp >= 2'd2) e_code = 2'd2;
      else e_code = 2'd0;
      if (e_code == 2'd0) e_rdata = cfg_r_data;
      e_lat = ar_delay + r_delay + 3;
    end
    exp_q.push_back({e_code, e_rdata});
    aw0 = aw_seen; w0 = w_seen; ar0 = ar_seen;

    @(negedge clock);
    req_valid = 1'b1; req_write = wr; req_addr = addr; req_size = size;
    req_wdata = wdata; req_wstrb = wstrb;
    cyc = 0;
    while (!req_ready && cyc < 100) begin @(negedge clock); cyc++; end
    chk({tag, "_req_ready"}, req_ready, 1'b1);
    @(negedge clock);
    req_valid = 1'b0;
    req_addr = AW'($urandom); req_size = 3'($urandom); req_write = 1'($urandom);
    req_wdata = {$urandom, $urandom}; req_wstrb = SW'($urandom);
    cyc = 1;
    while (!resp_valid && cyc < 300) begin @(negedge clock); cyc++; end
    chk({tag, "_resp_valid"}, resp_valid, 1'b1);
    chk({tag, "_latency"}, cyc, e_lat);
    e = exp_q.pop_front();
    chk({tag, "_code"}, resp_code, e[65:64]);
    chk({tag, "_err"}, resp_err, e[65:64] != 2'd0);
    chk({tag, "_rdata"}, resp_rdata, e[63:0]);
    chk({tag, "_req_ready_busy"}, req_ready, 1'b0);
    for (int i = 0; i < hold; i++) begin
      @(negedge clock);
      chk({tag, "_hold_valid"}, resp_valid, 1'b1);
      chk({tag, "_hold_code"}, resp_code, e[65:64]);
      chk({tag, "_hold_rdata"}, resp_rdata, e[63:0]);
    end
    resp_ready = 1'b1;
    @(negedge clock);
    resp_ready = 1'b0;
    chk({tag, "_resp_done"}, resp_valid, 1'b0);
    chk({tag, "_req_ready_after"}, req_ready, 1'b1);
    if (misal) begin
      chk({tag, "_aw_cnt"}, aw_seen - aw0, 0);
      chk({tag, "_w_cnt"}, w_seen - w0, 0);
      chk({tag, "_ar_cnt"}, ar_seen - ar0, 0);
    end else if (wr) begin
      chk({tag, "_aw_cnt"}, aw_seen - aw0, 1);
      chk({tag, "_w_cnt"}, w_seen - w0, 1);
      chk({tag, "_ar_cnt"}, ar_seen - ar0, 0);
      chk({tag, "_aw_addr"}, cap_aw_addr, addr);
      chk({tag, "_aw_size"}, cap_aw_size, size);
      chk({tag, "_aw_len"}, cap_aw_len, 8'd0);
      chk({tag, "_aw_burst"}, cap_aw_burst, 2'b01);
      chk({tag, "_aw_id"}, cap_aw_id, 4'd0);
      chk({tag, "_w_data"}, cap_w_data, wdata);
      chk({tag, "_w_strb"}, cap_w_strb, wstrb);
      chk({tag, "_w_last"}, cap_w_last, 1'b1);
    end else begin
      chk({tag, "_ar_cnt"}, ar_seen - ar0, 1);
      chk({tag, "_aw_cnt"}, aw_seen - aw0, 0);
      chk({tag, "_w_cnt"}, w_seen - w0, 0);
      chk({tag, "_ar_addr"}, cap_ar_addr, addr);
      chk({tag, "_ar_size"}, cap_ar_size, size);
      chk({tag, "_ar_len"}, cap_ar_len, 8'd0);
      chk({tag, "_ar_burst"}, cap_ar_burst, 2'b01);
      chk({tag, "_ar_id"}, cap_ar_id, 4'd0);
    end
    chk({tag, "_b_ready_order"}, proto_viol, 0);
  endtask

  // ---------------- directed + random sequence ----------------
  initial begin
    int cyc;
    logic        r_wr;
    logic [2:0]  r_size;
    logic [AW-1:0] r_addr;
    reset = 1'b1;
    req_valid = 1'b0; req_write = 1'b0; req_addr = '0; req_size = '0;
    req_wdata = '0; req_wstrb = '0; resp_ready = 1'b0;
    slave_defaults();
    repeat (3) @(negedge clock);
    reset = 1'b0;
    @(negedge clock);
    check_idle("reset");

    do_txn("wr_basic", 1'b1, 31'h6001_0008, 3'd3, 64'hDEAD_BEEF_CAFE_F00D, 8'hFF, 0);

    cfg_r_data = 64'h0000_0000_1234_5678;
    do_txn("rd_basic", 1'b0, 31'h6000_0004, 3'd2, 64'd0, 8'h00, 0);

    do_txn("wr_misalign", 1'b1, 31'h6001_0003, 3'd1, 64'h1111, 8'h03, 0);
    do_txn("rd_size_big", 1'b0, 31'h6001_0000, 3'd5, 64'd0, 8'h00, 0);

    aw_delay = 5;
    do_txn("wr_aw_slow", 1'b1, 31'h6001_0010, 3'd3, 64'h0123_4567_89AB_CDEF, 8'hF0, 0);
    aw_delay = 0; w_delay = 5;
    do_txn("wr_w_slow", 1'b1, 31'h6001_0018, 3'd2, 64'hA5A5_A5A5_5A5A_5A5A, 8'h0F, 0);
    w_delay = 0;

    cfg_r_resp = 2'b11; cfg_r_data = 64'hFFFF_0000_FFFF_0000;
    do_txn("rd_decerr", 1'b0, 31'h6000_0008, 3'd3, 64'd0, 8'h00, 0);
    cfg_r_resp = 2'b00; cfg_r_id = 4'd5;
    do_txn("rd_bad_id", 1'b0, 31'h6000_0008, 3'd3, 64'd0, 8'h00, 0);
    cfg_r_id = 4'd0; cfg_r_last = 1'b0;
    do_txn("rd_no_last", 1'b0, 31'h6000_000C, 3'd2, 64'd0, 8'h00, 0);
    cfg_r_last = 1'b1; cfg_r_resp = 2'b01; cfg_r_data = 64'hC0DE_0000_0000_BEEF;
    do_txn("rd_exokay", 1'b0, 31'h6000_0010, 3'd3, 64'd0, 8'h00, 0);
    cfg_r_resp = 2'b00;
    cfg_b_resp = 2'b10;
    do_txn("wr_slverr", 1'b1, 31'h6001_0020, 3'd0, 64'h0000_0000_0000_0042, 8'h01, 0);
    cfg_b_resp = 2'b00; cfg_b_id = 4'd3;
    do_txn("wr_bad_id", 1'b1, 31'h6001_0022, 3'd1, 64'h0000_0000_BEEF_0000, 8'h0C, 0);
    cfg_b_id = 4'd0;

    cfg_r_data = 64'h5555_AAAA_1234_0000;
    do_txn("rd_hold", 1'b0, 31'h6000_0020, 3'd3, 64'd0, 8'h00, 4);

    // Reset while the read data phase is still outstanding.
    r_delay = 1000;
    @(negedge clock);
    req_valid = 1'b1; req_write = 1'b0; req_addr = 31'h6000_0040; req_size = 3'd3;
    @(negedge clock);
    req_valid = 1'b0;
    cyc = 0;
    while (!m_axi4.r_ready && cyc < 50) begin @(negedge clock); cyc++; end
    chk("mid_rd_state", dbg_state, ST_RD_R);
    chk("mid_rd_resp_valid", resp_valid, 1'b0);
    chk("mid_rd_req_ready", req_ready, 1'b0);
    reset = 1'b1;
    repeat (2) @(negedge clock);
    reset = 1'b0;
    @(negedge clock);
    check_idle("mid_reset");
    r_delay = 0;
    cfg_r_data = 64'h0BAD_F00D_0000_0001;
    do_txn("rd_after_reset", 1'b0, 31'h6000_0048, 3'd3, 64'd0, 8'h00, 0);

    // Randomized traffic against the rule-based model.
    for (int n = 0; n < 40; n++) begin
      aw_delay = $urandom_range(0, 3); w_delay = $urandom_range(0, 3);
      ar_delay = $urandom_range(0, 3); b_delay = $urandom_range(0, 3);
      r_delay = $urandom_range(0, 3);
      cfg_b_resp = 2'($urandom_range(0, 3)); cfg_r_resp = 2'($urandom_range(0, 3));
      cfg_b_id = ($urandom_range(0, 7) == 0) ? 4'($urandom_range(1, 15)) : 4'd0;
      cfg_r_id = ($urandom_range(0, 7) == 0) ? 4'($urandom_range(1, 15)) : 4'd0;
      cfg_r_last = ($urandom_range(0, 7) != 0);
      cfg_r_data = {$urandom, $urandom};
      r_wr = 1'($urandom);
      r_size = ($urandom_range(0, 9) == 0) ? 3'($urandom_range(4, 7)) : 3'($urandom_range(0, 3));
      r_addr = AW'($urandom);
      if ($urandom_range(0, 4) != 0) r_addr[2:0] = 3'd0;
      do_txn("rand", r_wr, r_addr, r_size, {$urandom, $urandom}, SW'($urandom),
             $urandom_range(0, 2));
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
